fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Instruction fetch/decode stage. Drives the upstream program memory and feeds opcode/address to the downstream operand-address delay stage and the execute/control logic.
- Holds the program counter (PC) and the instruction register (IR).
- Splits each 8-bit instruction into opcode[7:5] and address[4:0].
- Holds each instruction for an opcode-dependent number of execute cycles, then resolves the next PC: sequential, JMP target, or SKZ skip.

Parameters:
- ADDR_W, 5, width of PC, mem_addr and address.
- RESET_PC, 0, PC value after reset.
- ALU_CYC, 5, execute cycles for ADD/AND/XOR/LDA (opcodes 010–101).
- STO_CYC, 4, execute cycles for STO (110).
- CTRL_CYC, 3, execute cycles for SKZ (001) and JMP (111).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mem_rdata  input  8  instruction read data; valid the cycle after mem_rd.
- zero  input  1  accumulator-zero flag from execute.
- resume  input  1  one-cycle pulse that leaves HALT (feature-gated).
- mem_addr  output  ADDR_W  instruction fetch address; equals PC.
- mem_rd  output  1  fetch read strobe.
- opcode  output  3  decoded opcode, IR[7:5].
- address  output  ADDR_W  decoded operand address, IR[4:0].
- instr_valid  output  1  one-cycle pulse on the first execute cycle of each instruction.
- halted  output  1  high while in HALT.

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. Single clock domain.
- Reset, from any state:
  - state=FETCH, PC=RESET_PC, IR=0, counter=0.
  - opcode=0, address=0, instr_valid=0, halted=0, mem_rd=0.
  - mem_addr=RESET_PC.
- A reset asserted mid-instruction aborts that instruction; no PC update is applied.
- FSM states: FETCH, LOAD, EXEC, HALT.
- FETCH (1 cycle): mem_rd=1, mem_addr=PC. Next state LOAD.
- LOAD (1 cycle):
  - IR<=mem_rdata, PC<=PC+1, mem_rd=0.
  - Opcode 000 (HLT) → next state HALT. Otherwise, load counter with N-1 and go to EXEC.
  - N: ALU_CYC for 010–101, STO_CYC for 110, CTRL_CYC for 001/111.
- EXEC (N cycles):
  - opcode/address held stable from IR.
  - instr_valid=1 only in the first EXEC cycle.
  - Counter decrements each cycle.
  - On the cycle counter==0, the next PC is resolved and the state returns to FETCH:
    - JMP: PC<=address.
    - SKZ with zero==1 sampled that cycle: PC<=PC+1, skipping one instruction.
    - Otherwise PC is unchanged (already incremented in LOAD).
- HALT:
  - halted=1, mem_rd=0. opcode=000 and address held.
  - instr_valid pulses once on HALT entry.
  - PC keeps pointing past the HLT instruction.
- Instruction period: 2+N cycles. HLT: 2 cycles to HALT entry.
- PC arithmetic is modulo 2^ADDR_W:
  - Sequential 31→0.
  - SKZ taken at instruction address 30 → next fetch 0.
  - SKZ taken at instruction address 31 → next fetch 1.
- zero is ignored for every opcode except SKZ, and outside the last EXEC cycle.
- JMP to its own address is legal and loops forever.
- mem_rd is never high in two consecutive cycles.

Optional Feature:
- Macro: FETCH_DECODE_RESUME_EN.
- Defined: resume==1 in HALT → next state FETCH at the current PC and halted drops on that edge. resume outside HALT is ignored.
- Undefined: HALT is left only by rst. The resume port stays present but is unused.

Test Plan:
- Reset, mem[0]=8'h45 (ADD @5): mem_rd high in cycle 0 with mem_addr=0 → cycle 2: opcode=010, address=5, instr_valid=1. Next mem_rd in cycle 7 with mem_addr=1.
- Program STO @3, JMP @10 → STO holds 4 EXEC cycles. JMP holds 3 EXEC cycles, then the next fetch has mem_addr=10.
- SKZ at PC=4:
  - With zero=1 in the last EXEC cycle → next fetch mem_addr=6.
  - With zero=0 → next fetch mem_addr=5.
  - SKZ at PC=31 with zero=1 → next fetch 1.
- HLT at PC=2 → halted=1 from cycle 2 of that instruction; no mem_rd for 20 cycles. With the macro defined, a resume pulse → fetch at mem_addr=3 and halted=0. Without the macro, resume → no change.
- rst asserted during the 3rd EXEC cycle of ADD @7 at PC=9 → next cycle: all outputs at reset values, then a fetch from RESET_PC.
- Sequential NOP-free ADD chain from PC=31 → next fetch mem_addr=0 (wrap).

Source files
------------

// File: rtl/fetch_decode.sv
// fetch_decode: PC/IR fetch-decode stage holding each instruction for an opcode-dependent execute count.
// Define FETCH_DECODE_RESUME_EN to let a resume pulse leave HALT; otherwise only rst leaves HALT.
module fetch_decode #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                ALU_CYC  = 5,
  parameter int                STO_CYC  = 4,
  parameter int                CTRL_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        mem_rdata,
  input  logic              zero,
  input  logic              resume,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] address,
  output logic              instr_valid,
  output logic              halted
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam int CNT_W = 8;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              resume_req;

  function automatic logic [CNT_W-1:0] exec_len(input logic [2:0] op);
    case (op)
      OP_STO:         exec_len = CNT_W'(STO_CYC - 1);
      OP_SKZ, OP_JMP: exec_len = CNT_W'(CTRL_CYC - 1);
      default:        exec_len = CNT_W'(ALU_CYC - 1);
    endcase
  endfunction

`ifdef FETCH_DECODE_RESUME_EN
  assign resume_req = resume;
`else
  logic unused_resume;
  assign unused_resume = resume;
  assign resume_req    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    case (state_q)
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d  = mem_rdata;
        pc_d  = pc_q + ADDR_W'(1);
        vld_d = 1'b1;
        if (mem_rdata[7:5] == OP_HLT) begin
          state_d = HALT;
        end else begin
          state_d = EXEC;
          cnt_d   = exec_len(mem_rdata[7:5]);
        end
      end
      EXEC: begin
        // Next PC is resolved only in the final execute cycle; zero is sampled only here.
        if (cnt_q == '0) begin
          state_d = FETCH;
          if (ir_q[7:5] == OP_JMP)
            pc_d = ADDR_W'(ir_q[4:0]);
          else if (ir_q[7:5] == OP_SKZ && zero)
            pc_d = pc_q + ADDR_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALT: if (resume_req) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // The read strobe is suppressed while rst is held so every output sits at its reset value.
  assign mem_rd      = (state_q == FETCH) && !rst;
  assign mem_addr    = pc_q;
  assign opcode      = ir_q[7:5];
  assign address     = ADDR_W'(ir_q[4:0]);
  assign instr_valid = vld_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: expected fetch/decode events are queued, a negedge monitor compares.
module tb_fetch_decode;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_rdata;
  logic       zero;
  logic       resume = 1'b0;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic [2:0] opcode;
  logic [4:0] address;
  logic       instr_valid;
  logic       halted;

  logic [7:0] mem [32];
  int    cyc = 0;
  int    base = 0;
  int    zero_cyc = -100;
  int    n_chk = 0;
  int    n_fail = 0;
  string tname = "reset";
  bit    prev_rd = 1'b0;

  typedef struct {
    bit is_fetch;
    int cyc;
    int addr;
    int op;
    int halt;
  } exp_t;
  exp_t q[$];

  fetch_decode dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .zero(zero), .resume(resume),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .opcode(opcode), .address(address),
    .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  assign zero = ((cyc - base) == zero_cyc);

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, required %0d", tname, nm, act, exp);
    end
  endtask

  task automatic pf(input int c, input int a);
    exp_t e;
    e.is_fetch = 1'b1; e.cyc = c; e.addr = a; e.op = 0; e.halt = 0;
    q.push_back(e);
  endtask

  task automatic pd(input int c, input int op, input int a, input int h);
    exp_t e;
    e.is_fetch = 1'b0; e.cyc = c; e.addr = a; e.op = op; e.halt = h;
    q.push_back(e);
  endtask

  task automatic begin_test(input string nm);
    tname    = nm;
    rst      = 1'b1;
    zero_cyc = -100;
    q.delete();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic go();
    @(posedge clk); #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - base) < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fin(input int n);
    wait_rel(n);
    chk("drain", q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_address", address, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
  endtask

  always @(negedge clk) begin
    int   rel;
    exp_t e;
    rel = cyc - base;
    if (rst) begin
      prev_rd = 1'b0;
    end else begin
      if (mem_rd) chk("rd_gap", prev_rd, 0);
      if (mem_rd || instr_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s/unexpected_event: got mem_rd=%0d instr_valid=%0d mem_addr=%0d at cycle %0d, required none",
                   tname, mem_rd, instr_valid, mem_addr, rel);
        end else begin
          e = q.pop_front();
          chk("evt_kind", mem_rd, e.is_fetch);
          chk("evt_cycle", rel, e.cyc);
          if (e.is_fetch) begin
            chk("mem_addr", mem_addr, e.addr);
          end else begin
            chk("opcode", opcode, e.op);
            chk("address", address, e.addr);
            chk("halted", halted, e.halt);
          end
        end
      end
      prev_rd = mem_rd;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();

    begin_test("add_then_hlt");
    mem[0] = 8'h45; mem[1] = 8'h00;
    pf(0, 0); pd(2, 2, 5, 0); pf(7, 1); pd(9, 0, 0, 1);
    go();
    fin(32);

    begin_test("sto_jmp");
    mem[0] = 8'hC3; mem[1] = 8'hEA; mem[2] = 8'h45;
    pf(0, 0); pd(2, 6, 3, 0); pf(6, 1); pd(8, 7, 10, 0); pf(11, 10); pd(13, 0, 0, 1);
    go();
    fin(20);

    begin_test("skz4_taken");
    mem[0] = 8'hE4; mem[4] = 8'h20; mem[5] = 8'h41; mem[6] = 8'h00;
    pf(0, 0); pd(2, 7, 4, 0); pf(5, 4); pd(7, 1, 0, 0); pf(10, 6); pd(12, 0, 0, 1);
    go();
    zero_cyc = 9;
    fin(20);

    begin_test("skz4_not_taken");
    mem[0] = 8'hE4; mem[4] = 8'h20; mem[5] = 8'h00; mem[6] = 8'h41;
    pf(0, 0); pd(2, 7, 4, 0); pf(5, 4); pd(7, 1, 0, 0); pf(10, 5); pd(12, 0, 0, 1);
    go();
    zero_cyc = 8;
    fin(20);

    begin_test("skz31_wrap");
    mem[0] = 8'hFF; mem[31] = 8'h20; mem[1] = 8'h00;
    pf(0, 0); pd(2, 7, 31, 0); pf(5, 31); pd(7, 1, 0, 0); pf(10, 1); pd(12, 0, 0, 1);
    go();
    zero_cyc = 9;
    fin(20);

    begin_test("skz30_wrap");
    mem[0] = 8'hFE; mem[30] = 8'h20;
    pf(0, 0); pd(2, 7, 30, 0); pf(5, 30); pd(7, 1, 0, 0); pf(10, 0); pd(12, 7, 30, 0);
    go();
    zero_cyc = 9;
    fin(14);

    begin_test("zero_ignored_add");
    mem[0] = 8'h41; mem[1] = 8'h00;
    pf(0, 0); pd(2, 2, 1, 0); pf(7, 1); pd(9, 0, 0, 1);
    go();
    zero_cyc = 6;
    fin(14);

    begin_test("hlt_at_2");
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h00; mem[3] = 8'h45;
    pf(0, 0); pd(2, 2, 1, 0); pf(7, 1); pd(9, 2, 2, 0); pf(14, 2); pd(16, 0, 0, 1);
    go();
    wait_rel(4); resume = 1'b1;
    wait_rel(5); resume = 1'b0;
    wait_rel(15); chk("halted_load", halted, 0);
    wait_rel(16); chk("halted_entry", halted, 1);
    wait_rel(40);
    chk("halted_hold", halted, 1);
    chk("halt_opcode", opcode, 0);
    resume = 1'b1;
`ifdef FETCH_DECODE_RESUME_EN
    pf(41, 3); pd(43, 2, 5, 0);
    wait_rel(41); resume = 1'b0;
    chk("halted_after_resume", halted, 0);
    fin(44);
`else
    wait_rel(41); resume = 1'b0;
    wait_rel(45); chk("halted_ignores_resume", halted, 1);
    fin(46);
`endif

    begin_test("mid_exec_reset");
    mem[0] = 8'hE9; mem[9] = 8'h47;
    pf(0, 0); pd(2, 7, 9, 0); pf(5, 9); pd(7, 2, 7, 0);
    go();
    wait_rel(9);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("drain_pre_reset", q.size(), 0);
    chk_reset_outputs();
    pf(0, 0); pd(2, 7, 9, 0);
    go();
    fin(4);

    begin_test("seq_wrap_31");
    mem[0] = 8'hFF; mem[31] = 8'h41;
    pf(0, 0); pd(2, 7, 31, 0); pf(5, 31); pd(7, 2, 1, 0); pf(12, 0);
    go();
    fin(13);

    begin_test("jmp_self");
    mem[0] = 8'hE0;
    pf(0, 0); pd(2, 7, 0, 0); pf(5, 0); pd(7, 7, 0, 0); pf(10, 0);
    go();
    fin(11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
